// File: rtl/brake_light_sequencer_if.sv
// Lamp-side signal bundle for brake_light_sequencer: vehicle-state inputs and lamp drive outputs.
interface brake_light_sequencer_if #(
  parameter int unsigned PWM_WIDTH = 10
);
  logic                 brakeActive;
  logic                 headLightActive;
  logic                 brakePWM;
  logic [PWM_WIDTH-1:0] brakeLevel;
  logic                 flashing;

  modport master (
    output brakeActive,
    output headLightActive,
    input  brakePWM,
    input  brakeLevel,
    input  flashing
  );

  modport slave (
    input  brakeActive,
    input  headLightActive,
    output brakePWM,
    output brakeLevel,
    output flashing
  );
endinterface

// File: rtl/brake_light_sequencer.sv
// Tail/brake lamp PWM sequencer: tail duty, attention flash burst on brake apply,
// steady brake duty and a stepped ramp-down on release.
module brake_light_sequencer #(
  parameter int unsigned PWM_WIDTH   = 10,
  parameter int unsigned TAIL_DUTY   = 31,
  parameter int unsigned BRAKE_DUTY  = 1023,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned FLASH_TICKS = 60,
  parameter int unsigned FLASH_COUNT = 3,
  parameter int unsigned RAMP_STEP   = 32
) (
  input  logic                    c50M,
  input  logic                    resetN,
  brake_light_sequencer_if.slave  lamp
);

  localparam int unsigned W   = PWM_WIDTH;
  localparam int unsigned W1  = PWM_WIDTH + 1;
  localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMW = (FLASH_TICKS > 0) ? $clog2(FLASH_TICKS + 1) : 1;
  localparam int unsigned FCW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  localparam logic [W-1:0]   TAIL       = W'(TAIL_DUTY);
  localparam logic [W-1:0]   BRAKE      = W'(BRAKE_DUTY);
  localparam logic [W1-1:0]  STEP       = W1'(RAMP_STEP);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TMW-1:0] PHASE_END  = TMW'(FLASH_TICKS);
  localparam logic [FCW-1:0] LAST_FLASH = FCW'((FLASH_COUNT == 0) ? 0 : FLASH_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FLASH_ON,
    FLASH_OFF,
    STEADY,
    RAMP
  } stateE;

  stateE          state, stateNext;
  logic           brkMeta, brkS, hdMeta, hdS;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [W-1:0]   base;
  logic [W-1:0]   target, targetNext;
  logic [TMW-1:0] phaseTimer, timerNext;
  logic [FCW-1:0] flashCnt, flashCntNext;
  logic [W1-1:0]  rampDiff;
  logic [W-1:0]   pwmCnt;
  logic [W-1:0]   dutyLevel;
  logic           pwmOut;
  logic           flashReg, flashingNext;

  always_ff @(posedge c50M or negedge resetN) begin
    if (!resetN) begin
      brkMeta <= 1'b0;
      brkS    <= 1'b0;
      hdMeta  <= 1'b0;
      hdS     <= 1'b0;
    end else begin
      brkMeta <= lamp.brakeActive;
      brkS    <= brkMeta;
      hdMeta  <= lamp.headLightActive;
      hdS     <= hdMeta;
    end
  end

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge c50M or negedge resetN) begin
    if (!resetN) presc <= '0;
    else         presc <= tick ? '0 : presc + 1'b1;
  end

  assign base     = hdS ? TAIL : '0;
  // Extra top bit flags a step that would go below zero.
  assign rampDiff = {1'b0, target} - STEP;

  always_ff @(posedge c50M or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      target     <= '0;
      phaseTimer <= '0;
      flashCnt   <= '0;
    end else begin
      state      <= stateNext;
      target     <= targetNext;
      phaseTimer <= timerNext;
      flashCnt   <= flashCntNext;
    end
  end

  // target is registered alongside state so it always holds the level of the state being entered.
  always_comb begin
    stateNext    = state;
    targetNext   = target;
    timerNext    = phaseTimer;
    flashCntNext = flashCnt;
    unique case (state)
      IDLE: begin
        targetNext = base;
        if (brkS) begin
          targetNext = BRAKE;
          if (FLASH_COUNT != 0) begin
            stateNext    = FLASH_ON;
            timerNext    = '0;
            flashCntNext = '0;
          end else begin
            stateNext = STEADY;
          end
        end
      end
      FLASH_ON: begin
        targetNext = BRAKE;
        if (!brkS) begin
          stateNext  = RAMP;
          targetNext = dutyLevel;
        end else if (phaseTimer == PHASE_END) begin
          stateNext  = FLASH_OFF;
          timerNext  = '0;
          targetNext = base;
        end else if (tick) begin
          timerNext = phaseTimer + 1'b1;
        end
      end
      FLASH_OFF: begin
        targetNext = base;
        if (!brkS) begin
          stateNext  = RAMP;
          targetNext = dutyLevel;
        end else if (phaseTimer == PHASE_END) begin
          targetNext = BRAKE;
          if (flashCnt == LAST_FLASH) begin
            stateNext = STEADY;
          end else begin
            stateNext    = FLASH_ON;
            flashCntNext = flashCnt + 1'b1;
            timerNext    = '0;
          end
        end else if (tick) begin
          timerNext = phaseTimer + 1'b1;
        end
      end
      STEADY: begin
        targetNext = BRAKE;
        if (!brkS) begin
          stateNext  = RAMP;
          targetNext = dutyLevel;
        end
      end
      RAMP: begin
        if (brkS) begin
          stateNext  = STEADY;
          targetNext = BRAKE;
        end else if (tick) begin
          if (rampDiff[W] || (rampDiff[W-1:0] <= base)) begin
            stateNext  = IDLE;
            targetNext = base;
          end else begin
            targetNext = rampDiff[W-1:0];
          end
        end
      end
      default: begin
        stateNext  = IDLE;
        targetNext = base;
      end
    endcase
  end

  always_comb begin
    flashingNext = (state == FLASH_ON) || (state == FLASH_OFF);
  end

  // Duty only changes at the frame wrap so no frame is ever cut short or stretched.
  always_ff @(posedge c50M or negedge resetN) begin
    if (!resetN) begin
      pwmCnt    <= '0;
      dutyLevel <= '0;
      pwmOut    <= 1'b0;
      flashReg  <= 1'b0;
    end else begin
      pwmCnt   <= pwmCnt + 1'b1;
      if (pwmCnt == '1) dutyLevel <= target;
      pwmOut   <= (pwmCnt < dutyLevel);
      flashReg <= flashingNext;
    end
  end

  assign lamp.brakePWM   = pwmOut;
  assign lamp.brakeLevel = dutyLevel;
  assign lamp.flashing   = flashReg;

endmodule

// File: doc/brake_light_sequencer.md
Name: brake_light_sequencer

Overview:
- Parametrised successor to the fixed-duty brake light driver.
- Owns its own PWM counter and adds configurable tail/brake duty levels and an attention flash burst on brake apply.
- Ramps down smoothly on brake release instead of snapping off.
- Sits between the vehicle-state inputs (brake switch, headlight enable) and the tail-lamp driver pin.

Parameters:
- PWM_WIDTH, 10: duty/counter width W; PWM frame = 2^W clocks.
- TAIL_DUTY, 31: duty while headlights on, brake off.
- BRAKE_DUTY, 1023: duty while braking, including flash-on phases; must be <= 2^W-1.
- TICK_DIV, 50000: c50M clocks per timing tick (1 ms at 50 MHz).
- FLASH_TICKS, 60: ticks per flash-on and per flash-off phase.
- FLASH_COUNT, 3: number of on/off flash pairs per brake apply; 0 disables flashing.
- RAMP_STEP, 32: duty decrement per tick during release ramp.

Ports:
- c50M  input  1  system clock, 50 MHz
- resetN  input  1  asynchronous active-low reset
- brakeActive  input  1  brake switch, asynchronous to c50M
- headLightActive  input  1  headlight enable, asynchronous to c50M
- brakePWM  output  1  lamp drive, high = lamp on
- brakeLevel  output  PWM_WIDTH  duty currently applied to the PWM comparator
- flashing  output  1  high while in FLASH_ON or FLASH_OFF

Behaviour:
- Reset (resetN low, asynchronous):
  - Outputs: brakePWM=0, brakeLevel=0, flashing=0.
  - State: state=IDLE; sync flops, tick prescaler, phase timer, flash counter, PWM counter, target and duty registers all 0.
  - Reset mid-flash or mid-ramp abandons the sequence; no resume after release.
- Input sync: brakeActive and headLightActive each pass through 2 flops. All logic uses the synced values (brkS, hdS).
- base = hdS ? TAIL_DUTY : 0. base is re-evaluated every cycle.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses tick for one clock at TICK_DIV-1. The prescaler is free-running and is not restarted by events.
- FSM states: IDLE, FLASH_ON, FLASH_OFF, STEADY, RAMP.
  - IDLE: target=base.
    - brkS=1 with FLASH_COUNT>0 -> FLASH_ON, flashCnt=0, phase timer=0.
    - brkS=1 with FLASH_COUNT=0 -> STEADY.
  - FLASH_ON: target=BRAKE_DUTY. Timer increments on tick; when it reaches FLASH_TICKS -> FLASH_OFF, timer=0.
  - FLASH_OFF: target=base. When timer reaches FLASH_TICKS:
    - flashCnt==FLASH_COUNT-1 -> STEADY.
    - otherwise -> FLASH_ON with flashCnt+1, timer=0.
  - STEADY: target=BRAKE_DUTY.
  - brkS=0 in FLASH_ON, FLASH_OFF or STEADY -> RAMP, with target loaded from the current brakeLevel.
  - RAMP, on each tick:
    - If target-RAMP_STEP <= base, or the subtraction would underflow: target=base -> IDLE.
    - Otherwise target -= RAMP_STEP.
    - Subtraction is done at W+1 bits to detect underflow. No wrap-around is permitted.
  - brkS=1 during RAMP -> STEADY directly; no re-flash.
  - brkS falling and a phase expiry in the same cycle: release wins -> RAMP.
- PWM:
  - W-bit counter free-runs 0..2^W-1 and wraps.
  - brakeLevel (duty register) loads target only when counter==2^W-1, so every frame is glitch-free.
  - brakePWM = registered (counter < brakeLevel). Duty 0 gives constant low; duty 2^W-1 gives low for one clock per frame.
- Latency:
  - Input edge to state change: 3 clocks (2 sync + FSM register).
  - State change to new duty on the pin: up to 2^W+1 further clocks (next frame boundary + output register).
- flashing is registered from the state (1 clock after entry).

Test Plan:
Bench parameters: W=4, TAIL_DUTY=3, BRAKE_DUTY=15, TICK_DIV=4, FLASH_TICKS=2, FLASH_COUNT=2, RAMP_STEP=4.
- Reset: hold resetN low with inputs toggling -> brakePWM=0, brakeLevel=0, flashing=0. Release with headLightActive=1 -> brakeLevel=3 at the first frame boundary; brakePWM high 3 of every 16 clocks.
- Brake apply with headlights on -> brakeLevel sequence 15,3,15,3 with flashing=1, each phase ~8 clocks of tick time aligned to frames. Then 15 steady, flashing=0.
- Release from STEADY, headlights on -> target 15,11,7, then 3 (7-4=3 <= base). After 3, state returns to IDLE.
- Release from STEADY, headlights off -> 15,11,7,3, then 0 (underflow clamp). Lamp constant low.
- Re-apply brake mid-RAMP (target=7) -> STEADY, brakeLevel=15, no flash (flashing stays 0).
- Rebuild with FLASH_COUNT=0 -> brake apply goes straight to STEADY. Separately, a 1-clock brakeActive glitch must still be captured if it spans a sample edge, and must then ramp down cleanly without X.
